// File: rtl/skid_fifo_slice.sv
// skid_fifo_slice: DEPTH-entry elastic valid/ready slice. Every output comes
// straight from a flop, which cuts both the data path and the ready path.
// Entry 0 is the output register. The other DEPTH-1 entries form a circular
// buffer that sits behind it.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush_i         synchronous discard of every stored entry
//   bwd_*           upstream stream (data/valid in, ready out)
//   fwd_*           downstream stream (data/valid out, ready in)
//   count_o         number of entries held, 0..DEPTH
//   almost_full_o   count_o >= AF_LEVEL
//   overflow_o      one-cycle pulse when a beat is dropped (MODE 1 only)
module skid_fifo_slice #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_LEVEL   = 3,
  parameter int unsigned MODE       = 0,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] bwd_data_i,
  input  logic                  bwd_valid_i,
  output logic                  bwd_ready_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  fwd_valid_o,
  input  logic                  fwd_ready_i,
  output logic [CNT_W-1:0]      count_o,
  output logic                  almost_full_o,
  output logic                  overflow_o
);

  localparam int unsigned BUF_D = DEPTH - 1;
  localparam int unsigned PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_D - 1);
  localparam bit DROP = (MODE == 1);

  logic [DATA_WIDTH-1:0] mem [BUF_D];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  logic                  pop;
  logic                  push;
  logic                  buf_has;
  logic                  out_load;
  logic                  take_direct;
  logic                  buf_rd;
  logic                  buf_wr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  valid_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  ovf_nxt;

  // Pointer advance. The wrap is explicit, so BUF_D need not be a power of 2.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes, buffer steering and next-state values.
  always_comb begin
    pop = fwd_valid_o & fwd_ready_i;
    if (DROP) begin
      push = bwd_valid_i & ((count_o != DEPTH_C) | pop);
    end else begin
      push = bwd_valid_i & bwd_ready_o;
    end
    // The output register is full whenever count_o > 0, so the buffer holds count_o-1 entries.
    buf_has     = (count_o >= CNT_W'(2));
    out_load    = ~fwd_valid_o | pop;
    // A beat bypasses the buffer only when the buffer is empty and the output register frees up.
    take_direct = out_load & ~buf_has & push;
    buf_rd      = out_load & buf_has;
    buf_wr      = push & ~take_direct;
    count_nxt   = count_o + CNT_W'(push) - CNT_W'(pop);

    valid_nxt = fwd_valid_o;
    data_nxt  = fwd_data_o;
    if (out_load) begin
      valid_nxt = buf_has | push;
    end
    if (buf_rd) begin
      data_nxt = mem[rd_ptr];
    end else if (take_direct) begin
      data_nxt = bwd_data_i;
    end

    ovf_nxt = DROP & bwd_valid_i & (count_o == DEPTH_C) & ~pop;
  end

  // Control flops. Flush returns them to their reset values.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      fwd_valid_o   <= 1'b0;
      bwd_ready_o   <= 1'b1;
      count_o       <= '0;
      almost_full_o <= 1'b0;
      overflow_o    <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      fwd_valid_o   <= valid_nxt;
      count_o       <= count_nxt;
      bwd_ready_o   <= DROP ? 1'b1 : (count_nxt < DEPTH_C);
      almost_full_o <= (count_nxt >= AF_C);
      overflow_o    <= ovf_nxt;
      if (buf_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (buf_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
    end
  end

  // Payload storage. These flops are deliberately not reset.
  always_ff @(posedge clk) begin
    fwd_data_o <= data_nxt;
    if (buf_wr && !rst && !flush_i) begin
      mem[wr_ptr] <= bwd_data_i;
    end
  end

  // Occupancy must stay within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (count_nxt <= DEPTH_C);
      assert (!(pop && (count_o == '0)));
    end
  end

endmodule

// File: tb/tb_skid_fifo_slice.sv
// Bench for skid_fifo_slice. It has three instances:
//   u0 DEPTH=4 MODE 0, u1 DEPTH=4 MODE 1, u2 DEPTH=5 MODE 0.
// Each instance is compared with a queue-level reference model.
module tb_skid_fifo_slice;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       vld [3];
  logic       rdy [3];
  logic       fl  [3];
  logic [7:0] din [3];

  logic       brdy0, fvld0, af0, ovf0;
  logic       brdy1, fvld1, af1, ovf1;
  logic       brdy2, fvld2, af2, ovf2;
  logic [7:0] dout0, dout1, dout2;
  logic [2:0] cnt0, cnt1, cnt2;

  skid_fifo_slice #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .flush_i(fl[0]), .bwd_data_i(din[0]), .bwd_valid_i(vld[0]),
    .bwd_ready_o(brdy0), .fwd_data_o(dout0), .fwd_valid_o(fvld0), .fwd_ready_i(rdy[0]),
    .count_o(cnt0), .almost_full_o(af0), .overflow_o(ovf0));

  skid_fifo_slice #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .flush_i(fl[1]), .bwd_data_i(din[1]), .bwd_valid_i(vld[1]),
    .bwd_ready_o(brdy1), .fwd_data_o(dout1), .fwd_valid_o(fvld1), .fwd_ready_i(rdy[1]),
    .count_o(cnt1), .almost_full_o(af1), .overflow_o(ovf1));

  skid_fifo_slice #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .flush_i(fl[2]), .bwd_data_i(din[2]), .bwd_valid_i(vld[2]),
    .bwd_ready_o(brdy2), .fwd_data_o(dout2), .fwd_valid_o(fvld2), .fwd_ready_i(rdy[2]),
    .count_o(cnt2), .almost_full_o(af2), .overflow_o(ovf2));

  // Reference model: one plain FIFO per instance, stored as a ring of 64 slots.
  int         depth_of [3] = '{4, 4, 5};
  int         mode_of  [3] = '{0, 1, 0};
  int         af_of    [3] = '{3, 3, 4};
  logic [7:0] mdata [3][64];
  int         mhead [3];
  int         mcnt  [3];
  logic       movf  [3];

  always @(posedge clk) begin
    bit m_pop;
    bit m_push;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mcnt[i] = 0; mhead[i] = 0; movf[i] = 1'b0;
      end else if (fl[i]) begin
        mcnt[i] = 0; movf[i] = 1'b0;
      end else begin
        m_pop  = (mcnt[i] > 0) && rdy[i];
        m_push = vld[i] && ((mcnt[i] < depth_of[i]) || (mode_of[i] == 1 && m_pop));
        movf[i] = (mode_of[i] == 1) && vld[i] && (mcnt[i] == depth_of[i]) && !m_pop;
        if (m_pop) begin
          mhead[i] = (mhead[i] + 1) % 64;
          mcnt[i]--;
        end
        if (m_push) begin
          mdata[i][(mhead[i] + mcnt[i]) % 64] = din[i];
          mcnt[i]++;
        end
      end
    end
  end

  // Bit layout: {valid, data (masked when not valid), count, ready, almost_full, overflow}.
  function automatic logic [14:0] pack_exp(input int i);
    logic v;
    v = (mcnt[i] > 0);
    return {v, v ? mdata[i][mhead[i]] : 8'h00, 3'(mcnt[i]),
            (mode_of[i] == 1) ? 1'b1 : (mcnt[i] < depth_of[i]),
            (mcnt[i] >= af_of[i]), movf[i]};
  endfunction

  function automatic logic [14:0] pack_obs(input int i);
    case (i)
      0:       return {fvld0, fvld0 ? dout0 : 8'h00, cnt0, brdy0, af0, ovf0};
      1:       return {fvld1, fvld1 ? dout1 : 8'h00, cnt1, brdy1, af1, ovf1};
      default: return {fvld2, fvld2 ? dout2 : 8'h00, cnt2, brdy2, af2, ovf2};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; rdy[i] = 1'b0; fl[i] = 1'b0; din[i] = 8'h00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b1; rdy[i] = 1'b1; din[i] = 8'h5A; fl[i] = 1'b0;
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pack_obs(i) !== 15'h0004) begin
        errors++;
        $display("FAIL reset inst%0d got %h exp %h", i, pack_obs(i), 15'h0004);
      end
    end
    rst = 1'b0;
    idle_all();
    tick();
  endtask

  // Back-to-back stream with ready held high. Each beat appears one cycle after it is pushed.
  task automatic test_stream();
    idle_all();
    rdy[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vld[0] = 1'b1;
      din[0] = 8'(8'h11 + k);
      tick();
      checks++;
      if (pack_obs(0) !== pack_exp(0)) begin
        errors++;
        $display("FAIL stream_model k%0d got %h exp %h", k, pack_obs(0), pack_exp(0));
      end
      checks++;
      if ({fvld0, dout0, cnt0, brdy0} !== {1'b1, 8'(8'h11 + k), 3'd1, 1'b1}) begin
        errors++;
        $display("FAIL stream_beat k%0d got v%b d%h c%0d r%b exp v1 d%h c1 r1",
                 k, fvld0, dout0, cnt0, brdy0, 8'(8'h11 + k));
      end
    end
    vld[0] = 1'b0;
    tick();
    checks++;
    if ({fvld0, cnt0} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL stream_drain got v%b c%0d exp v0 c0", fvld0, cnt0);
    end
  endtask

  // Fill against a stalled consumer, then release it. Check order and that nothing is lost.
  task automatic test_backpressure();
    logic [7:0] got[$];
    int idx = 0;
    bit done = 0;
    bit acc;
    idle_all();
    for (int c = 0; c < 80 && !done; c++) begin
      vld[0] = (idx < 12);
      din[0] = 8'(8'h11 + idx);
      rdy[0] = (c >= 6);
      acc = vld[0] && brdy0;
      if (fvld0 && rdy[0]) got.push_back(dout0);
      tick();
      if (acc) idx++;
      checks++;
      if (pack_obs(0) !== pack_exp(0)) begin
        errors++;
        $display("FAIL bp_model c%0d got %h exp %h", c, pack_obs(0), pack_exp(0));
      end
      if (c == 1) begin
        checks++;
        if ({cnt0, af0} !== {3'd2, 1'b0}) begin
          errors++;
          $display("FAIL bp_af_below got c%0d af%b exp c2 af0", cnt0, af0);
        end
      end
      if (c == 2) begin
        checks++;
        if ({cnt0, af0} !== {3'd3, 1'b1}) begin
          errors++;
          $display("FAIL bp_af_at got c%0d af%b exp c3 af1", cnt0, af0);
        end
      end
      if (c == 5) begin
        checks++;
        if ({cnt0, brdy0, af0, dout0} !== {3'd4, 1'b0, 1'b1, 8'h11}) begin
          errors++;
          $display("FAIL bp_full got c%0d r%b af%b d%h exp c4 r0 af1 d11", cnt0, brdy0, af0, dout0);
        end
      end
      if (idx == 12 && got.size() == 12) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL bp_timeout got %0d beats exp 12", got.size());
    end
    for (int j = 0; j < got.size(); j++) begin
      checks++;
      if (got[j] !== 8'(8'h11 + j)) begin
        errors++;
        $display("FAIL bp_order idx%0d got %h exp %h", j, got[j], 8'(8'h11 + j));
      end
    end
    idle_all();
    tick();
  endtask

  // Drop-new-on-full: extra beats are discarded and each drop pulses overflow.
  task automatic test_drop();
    logic [7:0] got[$];
    logic [7:0] exp_q[$] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA6};
    int pulses = 0;
    idle_all();
    for (int k = 0; k < 6; k++) begin
      vld[1] = 1'b1;
      din[1] = 8'(8'hA0 + k);
      tick();
      if (ovf1) pulses++;
      checks++;
      if (pack_obs(1) !== pack_exp(1)) begin
        errors++;
        $display("FAIL drop_model k%0d got %h exp %h", k, pack_obs(1), pack_exp(1));
      end
    end
    vld[1] = 1'b0;
    tick();
    if (ovf1) pulses++;
    checks++;
    if ({pulses, cnt1, brdy1} !== {32'd2, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL drop_summary got pulses%0d c%0d r%b exp pulses2 c4 r1", pulses, cnt1, brdy1);
    end
    // Drain. On the first drain cycle the slice is full, so push and pop happen together.
    rdy[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      vld[1] = (c == 0);
      din[1] = 8'hA6;
      if (fvld1) got.push_back(dout1);
      tick();
      checks++;
      if (pack_obs(1) !== pack_exp(1)) begin
        errors++;
        $display("FAIL drain_model c%0d got %h exp %h", c, pack_obs(1), pack_exp(1));
      end
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drop_count got %0d exp %0d", got.size(), exp_q.size());
    end
    for (int j = 0; j < got.size() && j < exp_q.size(); j++) begin
      checks++;
      if (got[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL drop_order idx%0d got %h exp %h", j, got[j], exp_q[j]);
      end
    end
    idle_all();
    tick();
  endtask

  // Flush discards a simultaneous push and pop and never raises overflow.
  task automatic test_flush();
    idle_all();
    for (int k = 0; k < 3; k++) begin
      vld[0] = 1'b1; din[0] = 8'(8'h31 + k);
      tick();
    end
    checks++;
    if (cnt0 !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre got c%0d exp c3", cnt0);
    end
    fl[0] = 1'b1; vld[0] = 1'b1; din[0] = 8'h34; rdy[0] = 1'b1;
    tick();
    checks++;
    if (pack_obs(0) !== 15'h0004) begin
      errors++;
      $display("FAIL flush_empty got %h exp %h", pack_obs(0), 15'h0004);
    end
    fl[0] = 1'b0; vld[0] = 1'b0;
    tick();
    checks++;
    if (pack_obs(0) !== 15'h0004) begin
      errors++;
      $display("FAIL flush_hold got %h exp %h", pack_obs(0), 15'h0004);
    end
    vld[0] = 1'b1; din[0] = 8'h35; rdy[0] = 1'b0;
    tick();
    checks++;
    if ({fvld0, dout0, cnt0} !== {1'b1, 8'h35, 3'd1}) begin
      errors++;
      $display("FAIL flush_after got v%b d%h c%0d exp v1 d35 c1", fvld0, dout0, cnt0);
    end
    // MODE 1 instance: flush while full with valid high must not raise overflow.
    idle_all();
    for (int k = 0; k < 4; k++) begin
      vld[1] = 1'b1; din[1] = 8'(8'h40 + k);
      tick();
    end
    fl[1] = 1'b1; vld[1] = 1'b1; din[1] = 8'h44;
    tick();
    checks++;
    if (pack_obs(1) !== 15'h0004) begin
      errors++;
      $display("FAIL flush_drop got %h exp %h", pack_obs(1), 15'h0004);
    end
    idle_all();
    tick();
  endtask

  // Reset in the middle of a transfer loses every held beat.
  task automatic test_reset_mid();
    idle_all();
    for (int k = 0; k < 3; k++) begin
      vld[2] = 1'b1; din[2] = 8'(8'h60 + k);
      tick();
    end
    rst = 1'b1; vld[2] = 1'b1; rdy[2] = 1'b1; din[2] = 8'h63;
    tick();
    checks++;
    if (pack_obs(2) !== 15'h0004) begin
      errors++;
      $display("FAIL rst_mid got %h exp %h", pack_obs(2), 15'h0004);
    end
    rst = 1'b0;
    idle_all();
    tick();
    checks++;
    if (pack_obs(2) !== pack_exp(2)) begin
      errors++;
      $display("FAIL rst_mid_after got %h exp %h", pack_obs(2), pack_exp(2));
    end
  endtask

  // Long random run on DEPTH=5. The producer holds its data until the beat is accepted.
  task automatic test_random();
    bit acc;
    int rdy_pct;
    idle_all();
    din[2] = 8'($urandom);
    for (int c = 0; c < 10000; c++) begin
      rdy_pct = ((c / 1000) % 2 == 1) ? 80 : 30;
      vld[2] = ($urandom_range(0, 99) < 60);
      rdy[2] = ($urandom_range(0, 99) < rdy_pct);
      fl[2]  = ($urandom_range(0, 499) == 0);
      acc = vld[2] && brdy2 && !fl[2];
      tick();
      if (acc) din[2] = 8'($urandom);
      checks++;
      if (pack_obs(2) !== pack_exp(2)) begin
        errors++;
        $display("FAIL random_model c%0d got %h exp %h", c, pack_obs(2), pack_exp(2));
      end
    end
    idle_all();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
